// File: rtl/dsp_slice_arbiter.sv
// Shares one (D+B)*A+C DSP slice between two burst requesters: round-robin
// grant with burst lock, C skew alignment, and routing of each P result to its issuer.
module dsp_slice_arbiter #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned C_SKEW  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s0_valid,
  output logic        s0_ready,
  input  logic        s0_last,
  input  logic [17:0] s0_a,
  input  logic [17:0] s0_b,
  input  logic [17:0] s0_d,
  input  logic [47:0] s0_c,
  input  logic        s1_valid,
  output logic        s1_ready,
  input  logic        s1_last,
  input  logic [17:0] s1_a,
  input  logic [17:0] s1_b,
  input  logic [17:0] s1_d,
  input  logic [47:0] s1_c,
  output logic [17:0] dsp_a,
  output logic [17:0] dsp_b,
  output logic [17:0] dsp_d,
  output logic [47:0] dsp_c,
  input  logic [47:0] dsp_p,
  output logic        r0_valid,
  output logic        r1_valid,
  output logic [47:0] r_p,
  output logic        busy
);

  localparam int unsigned OPW = 18;
  localparam int unsigned CW  = 48;
  localparam int unsigned CDW = C_SKEW * CW;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BURST0 = 2'd1,
    BURST1 = 2'd2
  } state_t;

  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic [OPW-1:0] d;
    logic [CW-1:0]  c;
  } beat_t;

  state_t             state;
  state_t             state_nxt;
  logic               last_grant;
  logic               last_grant_nxt;
  logic               xfer0;
  logic               xfer1;
  beat_t              beat_sel;
  logic [CDW-1:0]     c_dly;
  logic [LATENCY-1:0] tag_v;
  logic [LATENCY-1:0] tag_v_nxt;
  logic [LATENCY-1:0] tag_id;
  logic [LATENCY-1:0] tag_id_nxt;
  logic               busy_nxt;

  // Grant, burst lock, beat selection and next-state of the tag pipeline
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    s0_ready       = 1'b0;
    s1_ready       = 1'b0;
    beat_sel       = '0;
    case (state)
      IDLE: begin
        s0_ready = s0_valid & (~s1_valid | last_grant);
        s1_ready = s1_valid & (~s0_valid | ~last_grant);
      end
      BURST0:  s0_ready = 1'b1;
      BURST1:  s1_ready = 1'b1;
      default: ;
    endcase
    if (rst) begin
      s0_ready = 1'b0;
      s1_ready = 1'b0;
    end
    xfer0 = s0_valid & s0_ready;
    xfer1 = s1_valid & s1_ready;
    if (xfer0) begin
      last_grant_nxt = 1'b0;
      state_nxt      = s0_last ? IDLE : BURST0;
      beat_sel       = '{a: s0_a, b: s0_b, d: s0_d, c: s0_c};
    end else if (xfer1) begin
      last_grant_nxt = 1'b1;
      state_nxt      = s1_last ? IDLE : BURST1;
      beat_sel       = '{a: s1_a, b: s1_b, d: s1_d, c: s1_c};
    end
    tag_v_nxt  = LATENCY'({tag_v, xfer0 | xfer1});
    tag_id_nxt = LATENCY'({tag_id, xfer1});
    busy_nxt   = (state_nxt != IDLE) | (|tag_v_nxt);
  end

  // Idle cycles push zero beats so the slice never sees stale operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      dsp_a      <= '0;
      dsp_b      <= '0;
      dsp_d      <= '0;
      dsp_c      <= '0;
      c_dly      <= '0;
      tag_v      <= '0;
      tag_id     <= '0;
      r0_valid   <= 1'b0;
      r1_valid   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      dsp_a      <= beat_sel.a;
      dsp_b      <= beat_sel.b;
      dsp_d      <= beat_sel.d;
      c_dly      <= CDW'({c_dly, beat_sel.c});
      dsp_c      <= c_dly[CDW-1 -: CW];
      tag_v      <= tag_v_nxt;
      tag_id     <= tag_id_nxt;
      r0_valid   <= tag_v[LATENCY-1] & ~tag_id[LATENCY-1];
      r1_valid   <= tag_v[LATENCY-1] & tag_id[LATENCY-1];
      busy       <= busy_nxt;
    end
  end

  assign r_p = dsp_p;

endmodule

// File: tb/tb_dsp_slice_arbiter.sv
// Bench for dsp_slice_arbiter: directed scenarios plus random bursts, checked
// cycle by cycle against a transaction-level model of grants and results.
`timescale 1ns/1ps
module tb_dsp_slice_arbiter;

  typedef struct {
    logic [17:0] a;
    logic [17:0] b;
    logic [17:0] d;
    logic [47:0] c;
    logic        last;
    int          gap;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s0_valid, s0_ready, s0_last, s1_valid, s1_ready, s1_last;
  logic [17:0] s0_a, s0_b, s0_d, s1_a, s1_b, s1_d;
  logic [47:0] s0_c, s1_c;
  logic [17:0] dsp_a, dsp_b, dsp_d;
  logic [47:0] dsp_c, dsp_p, r_p;
  logic        r0_valid, r1_valid, busy;

  dsp_slice_arbiter dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_last(s0_last),
    .s0_a(s0_a), .s0_b(s0_b), .s0_d(s0_d), .s0_c(s0_c),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_last(s1_last),
    .s1_a(s1_a), .s1_b(s1_b), .s1_d(s1_d), .s1_c(s1_c),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_d(dsp_d), .dsp_c(dsp_c), .dsp_p(dsp_p),
    .r0_valid(r0_valid), .r1_valid(r1_valid), .r_p(r_p), .busy(busy)
  );

  always #5 clk = ~clk;

  // Slice stand-in: B0/B1/M/P stages on A/B/D, C captured one stage before P
  logic [47:0] sl_m1, sl_m2, sl_m3, sl_c;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sl_m1 <= '0; sl_m2 <= '0; sl_m3 <= '0; sl_c <= '0; dsp_p <= '0;
    end else begin
      sl_m1 <= (48'(dsp_d) + 48'(dsp_b)) * 48'(dsp_a);
      sl_m2 <= sl_m1;
      sl_m3 <= sl_m2;
      sl_c  <= dsp_c;
      dsp_p <= sl_m3 + sl_c;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  beat_t q0[$];
  beat_t q1[$];
  beat_t st0, st1;
  logic  v0, v1;
  int    wait0, wait1;
  int    owner;
  int    lg;

  bit          ev [16];
  int          eid[16];
  logic [47:0] ep [16];
  logic [17:0] ea [16];
  logic [17:0] eb [16];
  logic [17:0] ed [16];
  logic [47:0] ec [16];

  int          log_id[$];
  logic [47:0] log_p[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [47:0] ref_p(input beat_t bt);
    longint unsigned s;
    s = (longint'(bt.d) + longint'(bt.b)) * longint'(bt.a) + longint'(bt.c);
    return 48'(s);
  endfunction

  task automatic clear_model();
    owner = -1; lg = 1; v0 = 1'b0; v1 = 1'b0; wait0 = 0; wait1 = 0;
    q0.delete(); q1.delete(); log_id.delete(); log_p.delete();
    for (int i = 0; i < 16; i++) begin
      ev[i] = 1'b0; eid[i] = 0; ep[i] = '0; ea[i] = '0; eb[i] = '0; ed[i] = '0; ec[i] = '0;
    end
  endtask

  task automatic schedule(input int n, input beat_t bt);
    ea[(cyc+1)%16] = bt.a;
    eb[(cyc+1)%16] = bt.b;
    ed[(cyc+1)%16] = bt.d;
    ec[(cyc+3)%16] = bt.c;
    ev[(cyc+5)%16] = 1'b1;
    eid[(cyc+5)%16] = n;
    ep[(cyc+5)%16] = ref_p(bt);
    lg = n;
    owner = bt.last ? -1 : n;
  endtask

  // One clock: check registered outputs, present inputs, check ready, advance model
  task automatic tick();
    int s, pend;
    logic er0, er1;
    @(negedge clk);
    cyc++;
    s = cyc % 16;
    pend = 0;
    for (int k = 1; k <= 4; k++) if (ev[(cyc+k)%16]) pend++;
    check("busy", 64'(busy), 64'(owner != -1 || pend != 0));
    check("r0_valid", 64'(r0_valid), 64'(ev[s] && eid[s] == 0));
    check("r1_valid", 64'(r1_valid), 64'(ev[s] && eid[s] == 1));
    if (ev[s]) check("r_p", 64'(r_p), 64'(ep[s]));
    if (r0_valid || r1_valid) begin
      log_id.push_back(r1_valid ? 1 : 0);
      log_p.push_back(r_p);
    end
    check("dsp_a", 64'(dsp_a), 64'(ea[s]));
    check("dsp_b", 64'(dsp_b), 64'(eb[s]));
    check("dsp_d", 64'(dsp_d), 64'(ed[s]));
    check("dsp_c", 64'(dsp_c), 64'(ec[s]));
    ev[s] = 1'b0; ea[s] = '0; eb[s] = '0; ed[s] = '0; ec[s] = '0;

    if (!v0 && q0.size() > 0) begin
      if (wait0 < q0[0].gap) wait0++;
      else begin st0 = q0.pop_front(); v0 = 1'b1; wait0 = 0; end
    end
    if (!v1 && q1.size() > 0) begin
      if (wait1 < q1[0].gap) wait1++;
      else begin st1 = q1.pop_front(); v1 = 1'b1; wait1 = 0; end
    end
    s0_valid = v0; s0_last = st0.last; s0_a = st0.a; s0_b = st0.b; s0_d = st0.d; s0_c = st0.c;
    s1_valid = v1; s1_last = st1.last; s1_a = st1.a; s1_b = st1.b; s1_d = st1.d; s1_c = st1.c;
    #1;
    er0 = 1'b0;
    er1 = 1'b0;
    if (!rst) begin
      if (owner == -1) begin
        er0 = v0 && (!v1 || lg == 1);
        er1 = v1 && (!v0 || lg == 0);
      end else begin
        er0 = (owner == 0);
        er1 = (owner == 1);
      end
    end
    check("s0_ready", 64'(s0_ready), 64'(er0));
    check("s1_ready", 64'(s1_ready), 64'(er1));
    if (v0 && er0) begin schedule(0, st0); v0 = 1'b0; end
    else if (v1 && er1) begin schedule(1, st1); v1 = 1'b0; end
  endtask

  // Asynchronous reset: outputs must clear before any clock edge
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_r_valid", 64'({r1_valid, r0_valid}), 64'd0);
    check("rst_ready", 64'({s1_ready, s0_ready}), 64'd0);
    check("rst_dsp_abd", 64'(dsp_a | dsp_b | dsp_d), 64'd0);
    check("rst_dsp_c", 64'(dsp_c), 64'd0);
    clear_model();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input int n, input logic [17:0] a, input logic [17:0] b,
                      input logic [17:0] d, input logic [47:0] c,
                      input logic last, input int gap);
    beat_t bt;
    bt.a = a; bt.b = b; bt.d = d; bt.c = c; bt.last = last; bt.gap = gap;
    if (n == 0) q0.push_back(bt);
    else        q1.push_back(bt);
  endtask

  task automatic run_queues(input int max_ticks);
    int t;
    t = 0;
    while ((q0.size() > 0 || q1.size() > 0 || v0 || v1) && t < max_ticks) begin
      tick();
      t++;
    end
    check("drain_timeout", 64'(q0.size() == 0 && q1.size() == 0 && !v0 && !v1), 64'd1);
    repeat (8) tick();
  endtask

  task automatic check_log(input string tag, input int idx, input int id, input logic [47:0] p);
    check({tag, "_id"}, (idx < log_id.size()) ? 64'(log_id[idx]) : 64'hdead, 64'(id));
    check({tag, "_p"},  (idx < log_p.size())  ? 64'(log_p[idx])  : 64'hdead, 64'(p));
  endtask

  initial begin
    int total;
    st0 = '{default: '0};
    st1 = '{default: '0};
    s0_valid = 1'b0; s0_last = 1'b0; s0_a = '0; s0_b = '0; s0_d = '0; s0_c = '0;
    s1_valid = 1'b0; s1_last = 1'b0; s1_a = '0; s1_b = '0; s1_d = '0; s1_c = '0;
    clear_model();
    #8;
    do_reset();

    // Single beat
    push(0, 18'd3, 18'd4, 18'd5, 48'd7, 1'b1, 0);
    run_queues(50);
    check("single_count", 64'(log_p.size()), 64'd1);
    check_log("single", 0, 0, 48'd34);

    // Tie after reset goes to s0, next tie to s1
    do_reset();
    push(0, 18'd1, 18'd1, 18'd1, 48'd0, 1'b1, 0);
    push(0, 18'd3, 18'd1, 18'd1, 48'd0, 1'b1, 0);
    push(1, 18'd2, 18'd1, 18'd1, 48'd1, 1'b1, 0);
    run_queues(50);
    check_log("tie0", 0, 0, 48'd2);
    check_log("tie1", 1, 1, 48'd5);
    check_log("tie2", 2, 0, 48'd6);

    // s1 burst lock with s0 waiting
    do_reset();
    push(1, 18'd1, 18'd1, 18'd1, 48'd1, 1'b0, 0);
    push(1, 18'd2, 18'd1, 18'd1, 48'd1, 1'b0, 0);
    push(1, 18'd3, 18'd1, 18'd1, 48'd1, 1'b1, 0);
    push(0, 18'd5, 18'd1, 18'd0, 48'd0, 1'b1, 1);
    run_queues(50);
    check_log("lock0", 0, 1, 48'd3);
    check_log("lock1", 1, 1, 48'd5);
    check_log("lock2", 2, 1, 48'd7);
    check_log("lock3", 3, 0, 48'd5);

    // C alignment across back-to-back beats
    do_reset();
    push(0, 18'd2, 18'd0, 18'd1, 48'd100, 1'b0, 0);
    push(0, 18'd1, 18'd0, 18'd1, 48'd0, 1'b1, 0);
    run_queues(50);
    check_log("skew0", 0, 0, 48'd102);
    check_log("skew1", 1, 0, 48'd1);

    // Idle gap inside an s0 burst keeps s1 locked out
    do_reset();
    push(0, 18'd4, 18'd1, 18'd1, 48'd0, 1'b0, 0);
    push(0, 18'd1, 18'd1, 18'd1, 48'd1, 1'b1, 5);
    push(1, 18'd2, 18'd2, 18'd2, 48'd2, 1'b1, 1);
    run_queues(60);
    check_log("gap0", 0, 0, 48'd8);
    check_log("gap1", 1, 0, 48'd3);
    check_log("gap2", 2, 1, 48'd10);

    // Reset with two beats in flight
    do_reset();
    push(0, 18'd1, 18'd2, 18'd3, 48'd4, 1'b1, 0);
    push(1, 18'd5, 18'd6, 18'd7, 48'd8, 1'b1, 0);
    tick();
    tick();
    @(posedge clk);
    #2;
    check("pre_rst_dsp_a", 64'(dsp_a), 64'd5);
    do_reset();
    repeat (10) tick();
    check("post_rst_results", 64'(log_p.size()), 64'd0);

    // Random bursts from both requesters
    do_reset();
    total = 0;
    for (int i = 0; i < 60; i++) begin
      int n, len;
      n = int'($urandom_range(0, 1));
      len = int'($urandom_range(1, 4));
      for (int j = 0; j < len; j++) begin
        push(n, 18'($urandom), 18'($urandom), 18'($urandom), 48'({$urandom, $urandom}),
             (j == len - 1), (j == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 2)));
        total++;
      end
    end
    run_queues(4000);
    check("rand_count", 64'(log_p.size()), 64'(total));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
